// File: rtl/noc_wrr_arb.sv
// noc_wrr_arb: packet-level weighted round-robin arbiter with starvation override.
// Winners hold a registered one-hot grant for a whole packet.
// Each agent may win up to weight[i] consecutive packets before the
// round-robin pointer moves on.
module noc_wrr_arb #(
   parameter  int NUM_AGENTS   = 4,
   parameter  int WEIGHT_W     = 4,
   parameter  int STARV_THRESH = 8,
   localparam int IDW          = (NUM_AGENTS > 2) ? $clog2(NUM_AGENTS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_AGENTS-1:0]          req,
   input  logic [NUM_AGENTS-1:0]          req_last,
   input  logic [NUM_AGENTS*WEIGHT_W-1:0] weight,
   input  logic                           gnt_ready,
   output logic [NUM_AGENTS-1:0]          grant,
   output logic                           grant_valid,
   output logic [IDW-1:0]                 grant_id,
   output logic [NUM_AGENTS-1:0]          starved
);

   localparam int WAIT_W = $clog2(STARV_THRESH + 1);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                  state_q;
   logic [NUM_AGENTS-1:0]   grant_q;
   logic                    grant_valid_q;
   logic [IDW-1:0]          grant_id_q;
   logic [IDW-1:0]          ptr_q;
   logic [IDW-1:0]          last_q;
   logic [WEIGHT_W-1:0]     cnt_q;
   logic [WAIT_W-1:0]       wait_q [NUM_AGENTS];
   logic [WAIT_W-1:0]       wait_d [NUM_AGENTS];
   logic [NUM_AGENTS-1:0]   starved_q;

   logic [NUM_AGENTS-1:0]   starv_req;
   logic [IDW-1:0]          win;
   logic [WEIGHT_W-1:0]     w_weight;
   logic [WEIGHT_W-1:0]     eff_w;
   logic [WEIGHT_W-1:0]     cnt_new;
   logic [IDW-1:0]          ptr_wrap;
   logic                    pkt_done;

   // Modulo-NUM_AGENTS wrap for ptr+k, which never exceeds 2*NUM_AGENTS-2.
   function automatic int wrap(input int v);
      return (v >= NUM_AGENTS) ? v - NUM_AGENTS : v;
   endfunction

   // Winner selection: lowest-index starved requester, else round-robin from ptr.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      win       = '0;
      starv_req = starved_q & req;
      // Scan from the far end so the first match in scan order is written last.
      for (int k = NUM_AGENTS - 1; k >= 0; k--) begin
         if (req[wrap(int'(ptr_q) + k)]) win = IDW'(wrap(int'(ptr_q) + k));
      end
      if (|starv_req) begin
         for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
            if (starv_req[i]) win = IDW'(i);
         end
      end
   end

   // Packet-completion and weight bookkeeping for the current owner.
   always_comb begin
      w_weight = weight[int'(grant_id_q) * WEIGHT_W +: WEIGHT_W];
      eff_w    = (w_weight == '0) ? WEIGHT_W'(1) : w_weight;
      cnt_new  = (grant_id_q == last_q) ? cnt_q + WEIGHT_W'(1) : WEIGHT_W'(1);
      ptr_wrap = (grant_id_q == IDW'(NUM_AGENTS - 1)) ? '0 : grant_id_q + IDW'(1);
      // A dropped request before the last beat is an abort, handled as completion.
      pkt_done = (state_q == BUSY) &&
                 (!req[grant_id_q] || (gnt_ready && req_last[grant_id_q]));
   end

   // Arbitration FSM with registered grant outputs and WRR pointer/credit state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         ptr_q         <= '0;
         last_q        <= '0;
         cnt_q         <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q       <= BUSY;
                  grant_q       <= NUM_AGENTS'(1) << win;
                  grant_valid_q <= 1'b1;
                  grant_id_q    <= win;
               end
            end
            BUSY: begin
               if (pkt_done) begin
                  state_q       <= IDLE;
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  grant_id_q    <= '0;
                  last_q        <= grant_id_q;
                  if (cnt_new >= eff_w) begin
                     ptr_q <= ptr_wrap;
                     cnt_q <= '0;
                  end else begin
                     ptr_q <= grant_id_q;
                     cnt_q <= cnt_new;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Per-agent wait counters: count ungranted request cycles, saturating at the threshold.
   always_comb begin
      for (int i = 0; i < NUM_AGENTS; i++) begin
         if (!req[i] || grant_q[i]) begin
            wait_d[i] = '0;
         end else if (wait_q[i] != WAIT_W'(STARV_THRESH)) begin
            wait_d[i] = wait_q[i] + WAIT_W'(1);
         end else begin
            wait_d[i] = wait_q[i];
         end
      end
   end

   // Wait counter and starvation flag registers. The flag is registered alongside
   // the counter, so it clears on the same edge the counter is cleared by a grant
   // and a starved agent is served exactly one packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the counter array is reset element by element; starvation must not survive a reset.
         for (int i = 0; i < NUM_AGENTS; i++) wait_q[i] <= '0;
         starved_q <= '0;
      end else begin
         for (int i = 0; i < NUM_AGENTS; i++) begin
            wait_q[i]    <= wait_d[i];
            starved_q[i] <= (wait_d[i] == WAIT_W'(STARV_THRESH));
         end
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign starved     = starved_q;

endmodule

// File: tb/tb_noc_wrr_arb.sv
// tb_noc_wrr_arb: directed stimulus with a behavioural WRR model compared every cycle,
// plus literal grant sequences and timing points for the key scenarios.
module tb_noc_wrr_arb;

   localparam int N  = 4;
   localparam int WW = 4;
   localparam int TH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  req_last = '0;
   logic [N*WW-1:0] weight = '0;
   logic          gnt_ready = 1'b0;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [1:0]    grant_id;
   logic [N-1:0]  starved;

   int checks = 0;
   int errors = 0;
   int gq[$];
   logic prev_gv = 1'b0;

   // Behavioural model state
   bit m_busy;
   int m_w, m_ptr, m_cnt, m_last;
   int m_wait [N];
   bit m_starv [N];

   noc_wrr_arb #(.NUM_AGENTS(N), .WEIGHT_W(WW), .STARV_THRESH(TH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .weight(weight),
      .gnt_ready(gnt_ready), .grant(grant), .grant_valid(grant_valid),
      .grant_id(grant_id), .starved(starved)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_seq(input string name, input int e[8], input int n);
      check({name, "_len"}, 32'(gq.size() >= n), 32'd1);
      for (int i = 0; i < n; i++)
         check($sformatf("%s[%0d]", name, i), (i < gq.size()) ? gq[i] : -1, e[i]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      req_last  = '0;
      gnt_ready = 1'b0;
      weight    = {N{4'd1}};
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      gq.delete();
   endtask

   // Model: rules applied directly with integer arithmetic and modulo scanning.
   always @(posedge clk or negedge rst_n) begin : model
      int nw, pick, cn, ew;
      if (!rst_n) begin
         m_busy <= 1'b0; m_w <= 0; m_ptr <= 0; m_cnt <= 0; m_last <= 0;
         for (int i = 0; i < N; i++) begin
            m_wait[i]  <= 0;
            m_starv[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] || (m_busy && m_w == i)) nw = 0;
            else nw = (m_wait[i] < TH) ? m_wait[i] + 1 : TH;
            m_wait[i]  <= nw;
            m_starv[i] <= (nw == TH);
         end
         if (!m_busy) begin
            if (req != '0) begin
               pick = -1;
               for (int i = 0; i < N; i++)
                  if (pick < 0 && m_starv[i] && req[i]) pick = i;
               for (int k = 0; k < N; k++)
                  if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
               m_busy <= 1'b1;
               m_w    <= pick;
            end
         end else if (!req[m_w] || (gnt_ready && req_last[m_w])) begin
            cn = (m_w == m_last) ? m_cnt + 1 : 1;
            ew = int'(weight[m_w*WW +: WW]);
            if (ew == 0) ew = 1;
            m_last <= m_w;
            m_busy <= 1'b0;
            if (cn >= ew) begin
               m_ptr <= (m_w + 1) % N;
               m_cnt <= 0;
            end else begin
               m_ptr <= m_w;
               m_cnt <= cn;
            end
         end
      end
   end

   // Compare DUT outputs against the model every falling edge.
   always @(negedge clk) begin : cmp
      logic [N-1:0] eg, es;
      int eid;
      eg = '0; es = '0; eid = 0;
      if (m_busy) begin
         eg[m_w] = 1'b1;
         eid     = m_w;
      end
      for (int i = 0; i < N; i++) es[i] = m_starv[i];
      check("grant",       32'(grant),       32'(eg));
      check("grant_valid", 32'(grant_valid), 32'(m_busy));
      check("grant_id",    32'(grant_id),    eid);
      check("starved",     32'(starved),     32'(es));
   end

   // Record the id of every new grant.
   always @(negedge clk) begin
      if (grant_valid === 1'b1 && !prev_gv) gq.push_back(int'(grant_id));
      prev_gv <= grant_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, time %0t, required < 200000", $time);
      $fatal(1);
   end

   initial begin
      int e[8];
      int held, sfirst;
      logic [N-1:0] g9, gs [6];

      // Reset state
      do_reset();
      check("rst_grant",   32'(grant),       32'd0);
      check("rst_valid",   32'(grant_valid), 32'd0);
      check("rst_starved", 32'(starved),     32'd0);

      // Equal weights, all requesting, 1-beat packets
      req = 4'b1111; req_last = 4'b1111; gnt_ready = 1'b1;
      repeat (10) tick();
      req = '0;
      repeat (2) tick();
      e = '{0, 1, 2, 3, 0, 0, 0, 0};
      check_seq("seq_rr", e, 5);

      // weight[0]=3, agents 0 and 1 requesting
      do_reset();
      weight = {4'd1, 4'd1, 4'd1, 4'd3};
      req = 4'b0011; req_last = 4'b0011; gnt_ready = 1'b1;
      repeat (16) tick();
      req = '0;
      repeat (2) tick();
      e = '{0, 0, 0, 1, 0, 0, 0, 1};
      check_seq("seq_wrr", e, 8);

      // 4-beat packet from agent 2 with toggling ready; agent 1 joins mid-packet
      do_reset();
      req = 4'b0100; req_last = '0; gnt_ready = 1'b1;
      held = 0; g9 = '0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (grant === 4'b0100) held++;
         if (c == 9) g9 = grant;
         gnt_ready   = (c % 2 == 1);
         req[2]      = (c <= 7);
         req_last[2] = (c == 7);
         req[1]      = (c >= 2 && c <= 9);
         req_last[1] = 1'b1;
      end
      req = '0;
      repeat (2) tick();
      check("held_cycles", held, 8);
      check("gnt_after_bubble", 32'(g9), 32'd2);
      e = '{2, 1, 0, 0, 0, 0, 0, 0};
      check_seq("seq_multibeat", e, 2);

      // Starvation: agent 0 hogs with weight 15, agent 3 waits
      do_reset();
      weight = {4'd1, 4'd1, 4'd1, 4'd15};
      req = 4'b1001; req_last = 4'b1001; gnt_ready = 1'b1;
      sfirst = -1;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (sfirst < 0 && starved[3] === 1'b1) sfirst = c;
      end
      req = '0;
      repeat (2) tick();
      check("starve_cycle", sfirst, 7);
      e = '{0, 0, 0, 0, 3, 0, 0, 0};
      check_seq("seq_starve", e, 6);

      // Reset mid-packet while another agent is starved
      do_reset();
      req = 4'b0100; req_last = '0; gnt_ready = 1'b1;
      tick();
      req[1] = 1'b1;
      repeat (8) tick();
      check("pre_rst_grant",   32'(grant),   32'd4);
      check("pre_rst_starved", 32'(starved), 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_grant",   32'(grant),       32'd0);
      check("mid_rst_starved", 32'(starved),     32'd0);
      check("mid_rst_valid",   32'(grant_valid), 32'd0);
      check("mid_rst_id",      32'(grant_id),    32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      gq.delete();
      tick();
      check("post_rst_grant", 32'(grant), 32'd2);
      req = '0;
      repeat (2) tick();
      e = '{1, 0, 0, 0, 0, 0, 0, 0};
      check_seq("seq_post_rst", e, 1);

      // Abort: agent 1 drops req before its last beat
      do_reset();
      req = 4'b1010; req_last = '0; gnt_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         gs[c] = grant;
         if (c == 2) req = 4'b1001;
      end
      req = '0;
      repeat (2) tick();
      check("abort_busy",   32'(gs[2]), 32'd2);
      check("abort_bubble", 32'(gs[3]), 32'd0);
      check("abort_next",   32'(gs[4]), 32'd8);
      e = '{1, 3, 0, 0, 0, 0, 0, 0};
      check_seq("seq_abort", e, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
